// File: rtl/tdm_pkg.sv
// TDM demux shared types and defaults.
// Imported by the slot counter and the demux top.
package tdm_pkg;

  localparam int DW_DEF  = 8;
  localparam int NCH_DEF = 3;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM demux.
// Load-to-1 on slot 0, increment with wrap, clear on loss of lock.
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (inc) begin
      cnt <= (cnt == CW'(NCH - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_1x3.sv
// Time-division demultiplexer: one sample stream to NCH slot lanes.
// Frames are assembled in a shadow buffer and published whole.
module tdm_demux_1x3
  import tdm_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [NCH*DW-1:0] ch_out,
  output logic              frame_valid,
  output logic              sync_err,
  output logic              locked
);

  localparam int CW = $clog2(NCH);

  state_t                     st, st_d;
  logic [CW-1:0]              cnt;
  logic [NCH-2:0][DW-1:0]     shadow;
  logic                       is_lock, at0, last;
  logic                       take_s0, take_d, miss, err, fin;

  always_comb begin
    is_lock = (st == LOCK);
    at0     = (cnt == '0);
    last    = (cnt == CW'(NCH - 1));
    take_s0 = din_valid & sync;
    take_d  = din_valid & ~sync & is_lock & ~at0;
    miss    = din_valid & ~sync & is_lock & at0;
    err     = din_valid & is_lock & (sync ? ~at0 : at0);
    fin     = take_d & last;
  end

  always_comb begin
    st_d = st;
    unique case (1'b1)
      take_s0: st_d = LOCK;
      miss:    st_d = HUNT;
      default: st_d = st;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= HUNT;
    end else begin
      st <= st_d;
    end
  end

  tdm_slot_cnt #(
    .NCH (NCH),
    .CW  (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (miss),
    .load1 (take_s0),
    .inc   (take_d),
    .cnt   (cnt)
  );

  // The last slot bypasses the shadow straight into ch_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      if (take_s0) begin
        shadow[0] <= din;
      end
      for (int k = 1; k < NCH - 1; k++) begin
        if (take_d && cnt == CW'(k)) begin
          shadow[k] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      if (fin) begin
        ch_out <= {din, shadow};
      end
      frame_valid <= fin;
      sync_err    <= err;
      locked      <= (st_d == LOCK);
    end
  end

endmodule

// File: doc/tdm_demux_1x3.md
TDM_DEMUX_1X3 -- requirements
Module: tdm_demux_1x3

Interface
REQ-001 SHALL have parameter DW, default 8: data width of each slot.
REQ-002 SHALL have parameter NCH, default 3: slots per frame; legal range 2..4.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, DW bits: time-multiplexed sample.
REQ-006 SHALL have port din_valid, input, 1 bit: din carries a sample this cycle.
REQ-007 SHALL have port sync, input, 1 bit: qualified by din_valid; marks the sample as slot 0.
REQ-008 SHALL have port ch_out, output, NCH*DW bits: last completed frame; slot k occupies bits [k*DW +: DW].
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when ch_out updates.
REQ-010 SHALL have port sync_err, output, 1 bit: one-cycle pulse on framing violation.
REQ-011 SHALL have port locked, output, 1 bit: high while in state LOCK.

Function
REQ-012 SHALL implement FSM states HUNT and LOCK; slot counter cnt, range 0..NCH-1.
REQ-013 HUNT: din_valid&&!sync SHALL be ignored; din_valid&&sync SHALL store din as slot 0, set cnt=1, go to LOCK.
REQ-014 LOCK, din_valid, cnt==0, sync=1: SHALL store slot 0 and set cnt=1.
REQ-015 LOCK, din_valid, cnt==0, sync=0 (missing sync): SHALL discard the sample, pulse sync_err, go to HUNT.
REQ-016 LOCK, din_valid, cnt!=0, sync=0: SHALL store din in shadow slot cnt and increment cnt; cnt wraps from NCH-1 to 0.
REQ-017 LOCK, din_valid, cnt!=0, sync=1 (early sync): SHALL pulse sync_err, discard the partial frame, store din as slot 0, set cnt=1, and stay in LOCK.
REQ-018 On the edge that accepts slot NCH-1, ch_out SHALL load shadow slots 0..NCH-2 plus din as slot NCH-1, and frame_valid SHALL be high for the following cycle only. Latency from last sample to output: 1 clock.
REQ-019 ch_out SHALL hold its value between frames; a partial or discarded frame SHALL never reach ch_out.
REQ-020 din_valid=0 SHALL freeze cnt and state; sync without din_valid SHALL be ignored.
REQ-021 Gaps of any length between samples of one frame SHALL be permitted.
REQ-022 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-023 While rst_n=0: state=HUNT, cnt=0, shadow=0, ch_out=0, frame_valid=0, sync_err=0, locked=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL stay in HUNT until the next sync.

Structure
REQ-025 Package tdm_pkg SHALL hold the state enum (HUNT, LOCK) and the DW/NCH defaults.
REQ-026 Slot counter SHALL be a sub-module tdm_slot_cnt with load-to-1, increment-with-wrap and clear; this is the only sub-module.

Verification (DW=8, NCH=3)
REQ-027 Reset, then samples with sync on the first: A1,B2,C3 -> after C3, ch_out={C3,B2,A1}, frame_valid=1 for one cycle, locked=1.
REQ-028 Samples 11,22 without sync after reset -> ignored; then sync+33,44,55 -> ch_out={55,44,33}, sync_err never asserted.
REQ-029 Locked; sync+01,02, then sync+0A,0B,0C -> sync_err pulse on the 0A cycle; ch_out={0C,0B,0A}; frame 01/02 never output.
REQ-030 Locked after a full frame; next sample 77 without sync -> sync_err pulse, locked=0, ch_out unchanged.
REQ-031 Frame D0,D1,D2 with 3-cycle din_valid=0 gaps, with sync pulsed during a gap -> ch_out={D2,D1,D0}, no sync_err.
REQ-032 rst_n low after sync+E0,E1 -> all outputs 0 asynchronously; after release, F2 without sync is ignored.
